// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array read-out path:
//   - default geometry constants (element width, array dimension, first-result
//     latency, row-buffer depth)
//   - collector FSM state encoding (IDLE / COLLECT / DRAIN)
//   - clamp_rows(): limits a requested row count to the buffer depth
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int N_DEF         = 3;
  localparam int FIRST_LAT_DEF = 3;
  localparam int MAX_ROWS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } coll_state_t;

  // Requested tile height limited to what the row buffer can hold.
  function automatic logic [3:0] clamp_rows(input logic [3:0] req,
                                            input logic [3:0] max_rows);
    logic [3:0] res;
    if (req > max_rows) begin
      res = max_rows;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// -----------------------------------------------------------------------------
// systolic_result_collector_if
// Row-stream handshake between the result collector and its consumer.
//   out_valid   : out_data holds a complete deskewed row
//   out_ready   : consumer accepts the row on this clock
//   out_data    : N elements of DATA_W bits, column j at [j*DATA_W +: DATA_W]
//   out_row_idx : index of the row currently presented
// Modports: master (collector side), slave (consumer side).
// -----------------------------------------------------------------------------
interface systolic_result_collector_if #(
  parameter int DATA_W = systolic_pkg::DATA_W_DEF,
  parameter int N      = systolic_pkg::N_DEF
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [N*DATA_W-1:0]   out_data;
  logic [3:0]            out_row_idx;

  modport master (
    output out_valid,
    output out_data,
    output out_row_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row_idx,
    output out_ready
  );

endinterface

// File: rtl/collector_row_buf.sv
// -----------------------------------------------------------------------------
// collector_row_buf
// MAX_ROWS x N register file holding one result tile.
// Each column has its own write enable and row address because the array
// output is skewed: in one cycle different columns land in different rows.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears contents)
//   wr_en     : per-column write enable
//   wr_addr   : per-column row address, column j at [j*AW +: AW]
//   wr_data   : per-column write data, column j at [j*DATA_W +: DATA_W]
//   rd_addr   : row read address
//   rd_data   : combinational read of the addressed row
// -----------------------------------------------------------------------------
module collector_row_buf #(
  parameter int DATA_W   = 32,
  parameter int N        = 3,
  parameter int MAX_ROWS = 8,
  parameter int AW       = $clog2(MAX_ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        wr_en,
  input  logic [N*AW-1:0]     wr_addr,
  input  logic [N*DATA_W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [N*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [MAX_ROWS][N];

  // Element storage: independent per-column writes, full clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < MAX_ROWS; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_r[r][c] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (wr_en[c]) begin
          mem_r[wr_addr[c*AW +: AW]][c] <= wr_data[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Single row read port.
  always_comb begin
    rd_data = {(N*DATA_W){1'b0}};
    for (int c = 0; c < N; c++) begin
      rd_data[c*DATA_W +: DATA_W] = mem_r[rd_addr][c];
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// -----------------------------------------------------------------------------
// systolic_result_collector
// South-edge read-out of the NxN weight-stationary systolic array. Captures the
// skewed column results leaving the bottom PE row, deskews them into whole rows
// in a tile buffer and streams the rows out over a valid/ready handshake.
// The array never stalls, so capture is unconditional; backpressure only
// delays delivery because the buffer holds the whole tile.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse with activation row 0 entering the array
//   num_rows    : rows in this tile (latched on an accepted start, max MAX_ROWS)
//   south_data  : bottom-row PE outputs, column j at [j*DATA_W +: DATA_W]
//   out_if      : row stream (master modport)
//   busy        : high whenever the FSM is not IDLE
//   done        : one-cycle pulse after the last row is accepted
// Build option:
//   COLLECTOR_RELU_EN : when defined, negative elements are clamped to 0 at
//                       capture (ReLU); otherwise elements are stored bit-exact.
// -----------------------------------------------------------------------------
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N         = N_DEF,
  parameter int FIRST_LAT = FIRST_LAT_DEF,
  parameter int MAX_ROWS  = MAX_ROWS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  num_rows,
  input  logic [N*DATA_W-1:0]         south_data,
  systolic_result_collector_if.master out_if,
  output logic                        busy,
  output logic                        done
);

  localparam int         AW         = $clog2(MAX_ROWS);
  localparam int         CW         = $clog2(FIRST_LAT + MAX_ROWS + N) + 1;
  localparam logic [3:0] MAX_ROWS_C = 4'(MAX_ROWS);

  coll_state_t          state_r;
  logic [CW-1:0]        cyc_r;
  logic [3:0]           nr_r;
  logic [3:0]           rows_done_r;
  logic [3:0]           rd_ptr_r;
  logic                 out_valid_r;
  logic [N*DATA_W-1:0]  out_data_r;
  logic [3:0]           out_row_idx_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 hs_s;
  logic [N-1:0]         cap_en_s;
  logic [N*AW-1:0]      cap_addr_s;
  logic [N*DATA_W-1:0]  cap_data_s;
  logic                 last_cap_s;
  logic [3:0]           rows_done_n_s;
  logic [3:0]           rd_ptr_n_s;
  logic                 row_avail_s;
  logic [N*DATA_W-1:0]  rd_row_s;
  logic [N*DATA_W-1:0]  fwd_row_s;

  // Per-column element conditioning before it enters the buffer.
  for (genvar j = 0; j < N; j++) begin : g_col
    logic [DATA_W-1:0] elem_s;
    assign elem_s = south_data[j*DATA_W +: DATA_W];
`ifdef COLLECTOR_RELU_EN
    assign cap_data_s[j*DATA_W +: DATA_W] = elem_s[DATA_W-1] ? {DATA_W{1'b0}} : elem_s;
`else
    assign cap_data_s[j*DATA_W +: DATA_W] = elem_s;
`endif
  end

  // Skew window per column: column j carries row (cyc - FIRST_LAT - j).
  always_comb begin
    cap_en_s   = {N{1'b0}};
    cap_addr_s = {(N*AW){1'b0}};
    for (int j = 0; j < N; j++) begin
      if ((state_r == COLLECT) &&
          (int'(cyc_r) >= FIRST_LAT + j) &&
          (int'(cyc_r) <  FIRST_LAT + j + int'(nr_r))) begin
        cap_en_s[j]             = 1'b1;
        cap_addr_s[j*AW +: AW]  = AW'(int'(cyc_r) - FIRST_LAT - j);
      end else begin
        cap_en_s[j]             = 1'b0;
      end
    end
  end

  // Next-state counters; a row completes when its last column is captured.
  always_comb begin
    hs_s          = out_valid_r & out_if.out_ready;
    last_cap_s    = (state_r == COLLECT) &&
                    (int'(cyc_r) == FIRST_LAT + int'(nr_r) + N - 2);
    rows_done_n_s = rows_done_r + {3'b000, cap_en_s[N-1]};
    rd_ptr_n_s    = rd_ptr_r + {3'b000, hs_s};
    row_avail_s   = (rd_ptr_n_s < rows_done_n_s);
  end

  collector_row_buf #(
    .DATA_W   (DATA_W),
    .N        (N),
    .MAX_ROWS (MAX_ROWS),
    .AW       (AW)
  ) u_row_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap_en_s),
    .wr_addr (cap_addr_s),
    .wr_data (cap_data_s),
    .rd_addr (rd_ptr_n_s[AW-1:0]),
    .rd_data (rd_row_s)
  );

  // Output row as it will be after this edge: bypass elements written now so
  // the registered row is visible the cycle after its last column lands.
  always_comb begin
    fwd_row_s = rd_row_s;
    for (int j = 0; j < N; j++) begin
      if (cap_en_s[j] && (cap_addr_s[j*AW +: AW] == rd_ptr_n_s[AW-1:0])) begin
        fwd_row_s[j*DATA_W +: DATA_W] = cap_data_s[j*DATA_W +: DATA_W];
      end else begin
        fwd_row_s[j*DATA_W +: DATA_W] = rd_row_s[j*DATA_W +: DATA_W];
      end
    end
  end

  // Collector FSM, counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cyc_r         <= {CW{1'b0}};
      nr_r          <= 4'd0;
      rows_done_r   <= 4'd0;
      rd_ptr_r      <= 4'd0;
      out_valid_r   <= 1'b0;
      out_data_r    <= {(N*DATA_W){1'b0}};
      out_row_idx_r <= 4'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (start && (num_rows != 4'd0)) begin
            state_r     <= COLLECT;
            nr_r        <= clamp_rows(num_rows, MAX_ROWS_C);
            cyc_r       <= {CW{1'b0}};
            rows_done_r <= 4'd0;
            rd_ptr_r    <= 4'd0;
            busy_r      <= 1'b1;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        COLLECT: begin
          cyc_r         <= cyc_r + CW'(1);
          rows_done_r   <= rows_done_n_s;
          rd_ptr_r      <= rd_ptr_n_s;
          out_valid_r   <= row_avail_s;
          out_data_r    <= fwd_row_s;
          out_row_idx_r <= rd_ptr_n_s;
          // The final capture is also the last row's completion, so the
          // tile can never be fully drained while still in COLLECT.
          if (last_cap_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= COLLECT;
          end
        end
        DRAIN: begin
          rd_ptr_r <= rd_ptr_n_s;
          if (hs_s && (rd_ptr_n_s == nr_r)) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r   <= row_avail_s;
            out_data_r    <= fwd_row_s;
            out_row_idx_r <= rd_ptr_n_s;
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_valid   = out_valid_r;
  assign out_if.out_data    = out_data_r;
  assign out_if.out_row_idx = out_row_idx_r;
  assign busy               = busy_r;
  assign done               = done_r;

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Sits on the south edge of the 3x3 weight-stationary systolic array; this is the read-out end of the skewed west-input feed.
- Captures the skewed per-column results leaving the bottom PE row and deskews them into complete output rows.
- Buffers the whole result tile and delivers it row by row to the downstream consumer over a valid/ready handshake.
- The array itself never stalls, so every capture is unconditional.

Parameters:
- DATA_W, 32, width of one result element.
- N, 3, array dimension (number of columns and of elements per output row).
- FIRST_LAT, 3, cycles from start until column 0 presents row 0.
- MAX_ROWS, 8, row-buffer depth (maximum rows per tile).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  one-cycle pulse, asserted in the same cycle the controller asserts compute with activation row 0
- num_rows  in  4  rows in this tile; latched on an accepted start
- south_data  in  N*DATA_W  bottom-row PE outputs; column j occupies bits [j*DATA_W +: DATA_W]
- out_valid  out  1  out_data holds a complete row
- out_ready  in  1  consumer accepts the row
- out_data  out  N*DATA_W  deskewed row, column j at the same bit position as its input
- out_row_idx  out  4  index of the row currently on out_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last row is accepted

Behaviour:
- Reset values: state=IDLE, cyc=0, rows_done=0, rd_ptr=0, out_valid=0, out_data=0, out_row_idx=0, busy=0, done=0.
- Reset mid-operation discards all buffered rows; out_valid is 0 after the reset edge.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - start=1 with num_rows!=0 → COLLECT; latch nr = min(num_rows, MAX_ROWS); clear cyc, rows_done, rd_ptr.
  - start with num_rows=0 is ignored.
  - start while busy is ignored, and does not disturb the current tile.
- COLLECT, every edge:
  - For each column j: if FIRST_LAT+j <= cyc < FIRST_LAT+j+nr, then buf[cyc-FIRST_LAT-j][j] <= south_j.
  - cyc increments.
  - When cyc == FIRST_LAT+r+N-1, row r is complete and rows_done increments.
  - On the edge with cyc == FIRST_LAT+nr+N-2 (last capture) → DRAIN.
- Output, in both COLLECT and DRAIN:
  - out_valid = (rd_ptr < rows_done); out_data = buf[rd_ptr]; out_row_idx = rd_ptr.
  - Outputs are registered from buffer state.
  - Row r is first visible the cycle after its column N-1 capture edge.
  - out_valid && out_ready → rd_ptr increments.
  - out_data/out_row_idx hold stable while out_valid=1 and out_ready=0.
- DRAIN: the handshake that makes rd_ptr == nr → IDLE, done=1 for one cycle, out_valid=0.
- Simultaneous events: a row completion and a handshake in the same cycle both take effect; rows_done and rd_ptr update independently.
- Backpressure only delays delivery; capture never waits and no data is lost, because the buffer holds the full tile.
- Arithmetic: values pass through unmodified; no truncation.

Optional Feature:
- Macro COLLECTOR_RELU_EN.
- When defined: each element is treated as signed two's complement and clamped to 0 if negative at capture time (ReLU on the array output).
- When undefined: elements are stored bit-exact.

Decomposition:
- Shared package systolic_pkg holds the state encoding (IDLE/COLLECT/DRAIN) and the default DATA_W/N constants.
- One natural sub-module, collector_row_buf: an MAX_ROWS x N element register file with per-column write enables and a single row read port.
- Top level holds the FSM, counters and handshake.

Test Plan:
- Basic tile: start with num_rows=3, bench drives south_j = 100*r+j at cyc = 3+r+j, out_ready=1.
  - Rows {0,1,2}, {100,101,102}, {200,201,202} appear with out_row_idx 0,1,2.
  - Row 0 out_valid rises the cycle after cyc=5; done pulses after the third accept.
- Backpressure: same stimulus, out_ready=0 until state=DRAIN, then toggled 1,0,1,0,1.
  - Identical rows in order; out_data stable while stalled; exactly three accepts, then done.
- Boundaries:
  - num_rows=0 → busy stays 0.
  - num_rows=12 → clamped to 8 rows.
  - start pulsed while busy → ignored; row count unchanged.
- Reset mid-COLLECT, after 2 captured columns:
  - out_valid=0 and busy=0 the next cycle.
  - A fresh 1-row tile afterwards yields only its own values.
- Feature on, with COLLECTOR_RELU_EN defined:
  - South values -5 and 7 → outputs 0 and 7.
  - With the macro undefined, -5 passes as 32'hFFFFFFFB.
